// File: rtl/xpb_table_gen.sv
// Builds T[k] = (k*B) mod M for k = 0..2**IDX_BITS-1 by repeated modular addition,
// and serves registered lookups by digit for the modular-square datapath.
module xpb_table_gen #(
  parameter int WIDTH    = 1024,
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    base,
  input  logic [WIDTH-1:0]    modulus,
  output logic                busy,
  output logic                done,
  output logic                table_valid,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [WIDTH-1:0]    rd_data
);

  localparam int DEPTH = 2**IDX_BITS;
  localparam logic [IDX_BITS-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, ADD, SUB} state_t;

  state_t              state, state_n;
  logic [WIDTH-1:0]    b_q, b_n, m_q, m_n, acc, acc_n;
  logic [WIDTH:0]      sum, sum_n, diff;
  logic [IDX_BITS-1:0] idx, idx_n, wr_idx;
  logic [WIDTH-1:0]    wr_data, sub_val;
  logic                busy_n, done_n, tv_n, we;

  logic [WIDTH-1:0]    tbl [DEPTH];

  always_comb begin
    state_n = state;
    b_n     = b_q;
    m_n     = m_q;
    acc_n   = acc;
    sum_n   = sum;
    idx_n   = idx;
    busy_n  = busy;
    done_n  = 1'b0;
    tv_n    = table_valid;
    we      = 1'b0;
    wr_idx  = idx;
    // acc < M and B < M, so one conditional subtract keeps acc reduced; the
    // carry bit must take part in the compare or wide moduli wrap silently.
    diff    = sum - {1'b0, m_q};
    sub_val = (sum >= {1'b0, m_q}) ? diff[WIDTH-1:0] : sum[WIDTH-1:0];
    wr_data = sub_val;
    case (state)
      IDLE: if (start) begin
        b_n     = base;
        m_n     = modulus;
        we      = 1'b1;
        wr_idx  = '0;
        wr_data = '0;
        acc_n   = '0;
        idx_n   = {{(IDX_BITS-1){1'b0}}, 1'b1};
        busy_n  = 1'b1;
        tv_n    = 1'b0;
        state_n = ADD;
      end
      ADD: begin
        sum_n   = {1'b0, acc} + {1'b0, b_q};
        state_n = SUB;
      end
      SUB: begin
        acc_n = sub_val;
        we    = 1'b1;
        idx_n = idx + 1'b1;
        if (idx == LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          tv_n    = 1'b1;
        end else begin
          state_n = ADD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_valid <= 1'b0;
      idx         <= '0;
      acc         <= '0;
      sum         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      rd_data     <= '0;
    end else begin
      state       <= state_n;
      busy        <= busy_n;
      done        <= done_n;
      table_valid <= tv_n;
      idx         <= idx_n;
      acc         <= acc_n;
      sum         <= sum_n;
      b_q         <= b_n;
      m_q         <= m_n;
      rd_data     <= tbl[rd_idx];
    end
  end

  // Storage is deliberately not reset; reading here sees the pre-write value.
  always_ff @(posedge clk) begin
    if (!reset && we) tbl[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Randomised bench for xpb_table_gen against a cycle-level model built from
// (k*B) mod M arithmetic, plus literal tables that pin the model.
module tb_xpb_table_gen;
  localparam int W  = 1024;
  localparam int IB = 4;
  localparam int N  = 16;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0]  base = '0, modulus = '1;
  logic [IB-1:0] rd_idx = '0;
  logic          busy, done, table_valid;
  logic [W-1:0]  rd_data;

  int checks = 0, failures = 0;

  int t5[N] = '{0,5,10,2,7,12,4,9,1,6,11,3,8,0,5,10};
  int t3[N] = '{0,3,6,9,1,4,7,10,2,5,8,0,3,6,9,1};

  always #5 clk = ~clk;

  xpb_table_gen #(.WIDTH(W), .IDX_BITS(IB)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .modulus(modulus),
    .busy(busy), .done(done), .table_valid(table_valid),
    .rd_idx(rd_idx), .rd_data(rd_data));

  function automatic logic [W-1:0] mulmod(input int k, input logic [W-1:0] b, input logic [W-1:0] m);
    logic [W+4:0] kk, p;
    kk = W'(k);
    p  = kk * {5'b0, b};
    p  = p % {5'b0, m};
    return p[W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got_lo=%h want_lo=%h", nm, act[191:0], exp[191:0]);
    end
  endtask

  // Model: entry k lands 2k edges after the accepting edge; reads see the old value.
  logic [W-1:0] mm[N];
  bit   [N-1:0] mk = '0;
  logic [W-1:0] lb, lm, e_rd;
  bit           e_busy, e_done, e_tv, rd_known, model_ok = 0;
  int           cnt;

  always @(posedge clk) begin
    if (reset) begin
      model_ok = 1; e_busy = 0; e_done = 0; e_tv = 0; e_rd = '0; rd_known = 1;
    end else begin
      e_rd = mm[rd_idx]; rd_known = mk[rd_idx]; e_done = 0;
      if (!e_busy) begin
        if (start) begin
          lb = base; lm = modulus; mm[0] = '0; mk[0] = 1;
          e_busy = 1; e_tv = 0; cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt % 2 == 0) begin
          mm[cnt/2] = mulmod(cnt/2, lb, lm); mk[cnt/2] = 1;
          if (cnt/2 == N-1) begin e_busy = 0; e_done = 1; e_tv = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("busy", W'(busy), W'(e_busy));
      chk("done", W'(done), W'(e_done));
      chk("table_valid", W'(table_valid), W'(e_tv));
      if (rd_known) chk("rd_data", rd_data, e_rd);
    end
  end

  task automatic launch(input logic [W-1:0] b, input logic [W-1:0] m);
    base = b; modulus = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int poke);
    int c = 0;
    while (!done && c < 100) begin
      rd_idx = IB'($urandom_range(0, N-1));
      if (c == poke) begin start = 1'b1; base = W'(7); end
      else start = 1'b0;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    checks++;
    if (c != 30) begin
      failures++;
      $display("FAIL done_latency got=%0d want=30", c);
    end
  endtask

  // sel: 0 = model arithmetic, 1 = B5/M13 literal, 2 = B3/M11 literal, 3 = M-k rule
  task automatic readout(input int sel, input logic [W-1:0] b, input logic [W-1:0] m);
    logic [W-1:0] exp;
    for (int k = 0; k < N; k++) begin
      rd_idx = IB'(k);
      @(negedge clk);
      case (sel)
        1:       exp = W'(t5[k]);
        2:       exp = W'(t3[k]);
        3:       exp = (k == 0) ? '0 : m - W'(k);
        default: exp = mulmod(k, b, m);
      endcase
      chk($sformatf("table[%0d]", k), rd_data, exp);
      if (sel != 0) chk($sformatf("model[%0d]", k), mm[k], exp);
    end
  endtask

  logic [W-1:0] rm, rb, wm;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_tv", W'(table_valid), '0);
    chk("rst_rd", rd_data, '0);
    reset = 1'b0;

    // basic build, then back-to-back start on the done cycle
    launch(W'(5), W'(13));
    wait_done(-1);
    chk("done_seen", W'(done), W'(1));
    launch(W'(3), W'(11));
    chk("b2b_tv_drop", W'(table_valid), '0);
    chk("b2b_busy", W'(busy), W'(1));
    wait_done(-1);
    @(negedge clk);
    readout(2, W'(3), W'(11));

    // start while busy is ignored
    launch(W'(5), W'(13));
    wait_done(5);
    @(negedge clk);
    readout(1, W'(5), W'(13));
    rd_idx = IB'(4);
    @(negedge clk);
    chk("rd_idx4", rd_data, W'(7));

    // abort mid-build
    launch(W'(5), W'(13));
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", W'(busy), '0);
    chk("abort_tv", W'(table_valid), '0);
    chk("abort_rd", rd_data, '0);
    reset = 1'b0;
    launch(W'(3), W'(11));
    wait_done(-1);
    @(negedge clk);
    readout(2, W'(3), W'(11));

    // wide carry: M = 2^W-3, B = M-1
    wm = '1;
    wm = wm - W'(2);
    launch(wm - W'(1), wm);
    wait_done(-1);
    @(negedge clk);
    readout(3, wm - W'(1), wm);

    // random operands
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < W/32; j++) rm[j*32 +: 32] = $urandom;
      if (r == 1) rm[W-1:W/2] = '0;
      if (rm == '0) rm = W'(1);
      for (int j = 0; j < W/32; j++) rb[j*32 +: 32] = $urandom;
      rb = rb % rm;
      launch(rb, rm);
      wait_done(-1);
      @(negedge clk);
      readout(0, rb, rm);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
